// File: rtl/rx_phase_sync.sv
`timescale 1ns/1ps
// rx_phase_sync: receive-side timing recovery for the PRBS9+BPSK+RC link.
// Accumulates |sample| per sampling phase over a 2^NWIN_LOG2-symbol window,
// picks the highest-energy phase, and slices the sign at that phase to emit
// one decided bit per symbol, qualified by a lock flag.
// Optional build macro RX_PHASE_FREEZE_EN: once locked, evaluations stop and
// o_phase/o_locked hold until i_enable falls or reset.
//
// Output protocol: o_bit_valid is a one-clock strobe with no back-pressure;
// o_bit is meaningful only in the clock where o_bit_valid=1, and downstream
// must qualify bits with o_locked. The FSM state is visible as state_q.
module rx_phase_sync #(
  parameter int NB        = 8,
  parameter int OS        = 4,
  parameter int NB_PHASE  = 2,
  parameter int NWIN_LOG2 = 6
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 i_enable,
  input  logic signed [NB-1:0] i_sample,
  output logic                 o_bit,
  output logic                 o_bit_valid,
  output logic [NB_PHASE-1:0]  o_phase,
  output logic                 o_locked
);

  localparam int NB_ACC = NB + NWIN_LOG2;
  localparam logic [NB_PHASE-1:0] PH_LAST = NB_PHASE'(OS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACQ   = 2'd1,
    ST_EVAL  = 2'd2,
    ST_TRACK = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [NB_PHASE-1:0]  ph_cnt_q, ph_cnt_d;
  logic [NWIN_LOG2-1:0] sym_cnt_q, sym_cnt_d;
  logic [NB_ACC-1:0]    acc_q [OS];
  logic [NB_ACC-1:0]    acc_d [OS];
  logic [NB_ACC-1:0]    acc_sum [OS];
  logic [NB_ACC-1:0]    shadow_q [OS];
  logic [NB_ACC-1:0]    shadow_d [OS];
  logic [NB_PHASE-1:0]  eval_idx_q, eval_idx_d;
  logic [NB_ACC-1:0]    best_val_q, best_val_d;
  logic [NB_PHASE-1:0]  best_idx_q, best_idx_d;
  logic                 upd_q, upd_d;
  logic [NB_PHASE-1:0]  prev_q, prev_d;
  logic                 prev_valid_q, prev_valid_d;
  logic [NB_PHASE-1:0]  o_phase_q, o_phase_d;
  logic                 o_locked_q, o_locked_d;
  logic                 o_bit_q, o_bit_d;
  logic                 o_bit_valid_q, o_bit_valid_d;

  logic [NB-1:0] sample_u;
  logic [NB-1:0] mag;
  logic          ph_last;
  logic          win_end;
  logic          frozen;

  // Magnitude of the incoming sample; the most negative code maps to 2^(NB-1).
  always_comb begin
    sample_u = i_sample;
    mag      = sample_u[NB-1] ? ((~sample_u) + NB'(1)) : sample_u;
  end

  // Window boundary detection and freeze qualification.
  always_comb begin
    ph_last = (ph_cnt_q == PH_LAST);
    win_end = i_enable && ph_last && (&sym_cnt_q);
`ifdef RX_PHASE_FREEZE_EN
    frozen  = o_locked_q;
`else
    frozen  = 1'b0;
`endif
  end

  // Per-phase running sum including this clock's sample.
  always_comb begin
    for (int p = 0; p < OS; p++) begin
      acc_sum[p] = acc_q[p] + ((NB_PHASE'(p) == ph_cnt_q) ? NB_ACC'(mag) : '0);
    end
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state; a low enable wins over everything, including window end.
  always_comb begin
    state_d = state_q;
    if (!i_enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_ACQ;
        ST_ACQ:   if (win_end) state_d = ST_EVAL;
        ST_EVAL:  if (eval_idx_q == PH_LAST) state_d = ST_TRACK;
        ST_TRACK: if (win_end && !frozen) state_d = ST_EVAL;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs and datapath: counters, accumulators, argmax scan, slicer.
  always_comb begin
    ph_cnt_d      = ph_cnt_q;
    sym_cnt_d     = sym_cnt_q;
    for (int p = 0; p < OS; p++) begin
      acc_d[p]    = acc_q[p];
      shadow_d[p] = shadow_q[p];
    end
    eval_idx_d    = eval_idx_q;
    best_val_d    = best_val_q;
    best_idx_d    = best_idx_q;
    upd_d         = 1'b0;
    prev_d        = prev_q;
    prev_valid_d  = prev_valid_q;
    o_phase_d     = o_phase_q;
    o_locked_d    = o_locked_q;
    o_bit_d       = o_bit_q;
    o_bit_valid_d = 1'b0;

    if (!i_enable) begin
      // Going idle: drop all evidence and lock, but keep the last phase.
      ph_cnt_d     = '0;
      sym_cnt_d    = '0;
      for (int p = 0; p < OS; p++) begin
        acc_d[p]    = '0;
        shadow_d[p] = '0;
      end
      eval_idx_d   = '0;
      prev_d       = '0;
      prev_valid_d = 1'b0;
      o_locked_d   = 1'b0;
    end else begin
      ph_cnt_d = ph_last ? '0 : (ph_cnt_q + NB_PHASE'(1));
      if (ph_last) sym_cnt_d = sym_cnt_q + NWIN_LOG2'(1);

      // At window end the completed sums move to shadow and the next window
      // starts empty with the following sample.
      for (int p = 0; p < OS; p++) begin
        if (win_end) begin
          shadow_d[p] = acc_sum[p];
          acc_d[p]    = '0;
        end else begin
          acc_d[p]    = acc_sum[p];
        end
      end

      if (ph_cnt_q == o_phase_q) begin
        o_bit_valid_d = 1'b1;
        o_bit_d       = i_sample[NB-1];
      end

      // One shadow entry per clock; strict compare keeps the lowest index on ties.
      if (state_q == ST_EVAL) begin
        if ((eval_idx_q == '0) || (shadow_q[eval_idx_q] > best_val_q)) begin
          best_val_d = shadow_q[eval_idx_q];
          best_idx_d = eval_idx_q;
        end
        if (eval_idx_q == PH_LAST) begin
          eval_idx_d = '0;
          upd_d      = 1'b1;
        end else begin
          eval_idx_d = eval_idx_q + NB_PHASE'(1);
        end
      end

      if (upd_q) begin
        o_phase_d    = best_idx_q;
        o_locked_d   = prev_valid_q && (best_idx_q == prev_q);
        prev_d       = best_idx_q;
        prev_valid_d = 1'b1;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ph_cnt_q      <= '0;
      sym_cnt_q     <= '0;
      for (int p = 0; p < OS; p++) begin
        acc_q[p]    <= '0;
        shadow_q[p] <= '0;
      end
      eval_idx_q    <= '0;
      best_val_q    <= '0;
      best_idx_q    <= '0;
      upd_q         <= 1'b0;
      prev_q        <= '0;
      prev_valid_q  <= 1'b0;
      o_phase_q     <= '0;
      o_locked_q    <= 1'b0;
      o_bit_q       <= 1'b0;
      o_bit_valid_q <= 1'b0;
    end else begin
      ph_cnt_q      <= ph_cnt_d;
      sym_cnt_q     <= sym_cnt_d;
      for (int p = 0; p < OS; p++) begin
        acc_q[p]    <= acc_d[p];
        shadow_q[p] <= shadow_d[p];
      end
      eval_idx_q    <= eval_idx_d;
      best_val_q    <= best_val_d;
      best_idx_q    <= best_idx_d;
      upd_q         <= upd_d;
      prev_q        <= prev_d;
      prev_valid_q  <= prev_valid_d;
      o_phase_q     <= o_phase_d;
      o_locked_q    <= o_locked_d;
      o_bit_q       <= o_bit_d;
      o_bit_valid_q <= o_bit_valid_d;
    end
  end

  assign o_bit       = o_bit_q;
  assign o_bit_valid = o_bit_valid_q;
  assign o_phase     = o_phase_q;
  assign o_locked    = o_locked_q;

endmodule

// File: tb/tb_rx_phase_sync.sv
`timescale 1ns/1ps
// tb_rx_phase_sync: stimulus streams with a chosen energy profile per phase,
// a behavioural window/argmax model, and a bit scoreboard fed at drive time.
module tb_rx_phase_sync;

  localparam int NB        = 8;
  localparam int OS        = 4;
  localparam int NB_PHASE  = 2;
  localparam int NWIN_LOG2 = 6;
  localparam int WIN       = OS * (1 << NWIN_LOG2);
`ifdef RX_PHASE_FREEZE_EN
  localparam bit FREEZE = 1'b1;
`else
  localparam bit FREEZE = 1'b0;
`endif

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 i_enable = 1'b0;
  logic signed [NB-1:0] i_sample = '0;
  logic                 o_bit;
  logic                 o_bit_valid;
  logic [NB_PHASE-1:0]  o_phase;
  logic                 o_locked;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  // Scoreboard of expected sliced bits.
  logic [0:0] exp_q[$];

  // Stimulus configuration.
  bit       mode_fixed;
  int       mag_m [OS];
  int       fix_m [OS];
  logic [8:0] lfsr;
  logic     cur_sign;

  // Reference model state.
  int                  w_m;
  int                  acc_m [OS];
  logic [NB_PHASE-1:0] exp_phase;
  logic                exp_locked;
  logic                prev_valid_m;
  logic [NB_PHASE-1:0] prev_m;
  logic [NB_PHASE-1:0] pend_best;
  int                  cd;
  logic                exp_valid;

  rx_phase_sync dut (
    .clock       (clock),
    .reset       (reset),
    .i_enable    (i_enable),
    .i_sample    (i_sample),
    .o_bit       (o_bit),
    .o_bit_valid (o_bit_valid),
    .o_phase     (o_phase),
    .o_locked    (o_locked)
  );

  // Clock.
  always #5 clock = ~clock;

  task automatic model_clear();
    w_m = 0;
    for (int p = 0; p < OS; p++) acc_m[p] = 0;
    exp_phase    = '0;
    exp_locked   = 1'b0;
    prev_valid_m = 1'b0;
    prev_m       = '0;
    cd           = 0;
    exp_valid    = 1'b0;
    exp_q.delete();
    lfsr         = 9'h1AA;
    cur_sign     = 1'b0;
    cyc          = 0;
  endtask

  // Assert reset (asynchronously, away from an edge), check, then release.
  task automatic do_reset();
    reset = 1'b1;
    #2;
    tests_run++;
    if (o_bit !== 1'b0 || o_bit_valid !== 1'b0 || o_phase !== '0 || o_locked !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs got bit=%b valid=%b phase=%0d locked=%b exp all 0",
               o_bit, o_bit_valid, o_phase, o_locked);
    end
    tests_run++;
    if (dut.state_q !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_state got=%0d exp=0", dut.state_q);
    end
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  // Drive one clock of stimulus, update the model, check the outputs.
  task automatic step();
    int ph;
    int mag;
    int best;
    logic fb;
    logic signed [NB-1:0] s;
    logic [0:0] got;
    s  = '0;
    ph = w_m % OS;
    if (i_enable) begin
      if (ph == 0 && !mode_fixed) begin
        fb       = lfsr[8] ^ lfsr[4];
        lfsr     = {lfsr[7:0], fb};
        cur_sign = fb;
      end
      if (mode_fixed) s = NB'(fix_m[ph]);
      else            s = cur_sign ? NB'(-mag_m[ph]) : NB'(mag_m[ph]);
      exp_valid = (NB_PHASE'(ph) == exp_phase);
      if (exp_valid) exp_q.push_back(s[NB-1]);
    end else begin
      exp_valid = 1'b0;
    end
    i_sample = s;
    @(posedge clock);
    #1;
    if (i_enable) begin
      mag = (int'(s) < 0) ? -int'(s) : int'(s);
      acc_m[ph] += mag;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          exp_locked   = prev_valid_m && (pend_best == prev_m);
          prev_m       = pend_best;
          prev_valid_m = 1'b1;
          exp_phase    = pend_best;
        end
      end
      if (w_m == WIN - 1) begin
        if (!(FREEZE && exp_locked)) begin
          best = 0;
          for (int p = 1; p < OS; p++) if (acc_m[p] > acc_m[best]) best = p;
          pend_best = NB_PHASE'(best);
          cd = 5;
        end
        for (int p = 0; p < OS; p++) acc_m[p] = 0;
      end
      w_m = (w_m + 1) % WIN;
    end else begin
      w_m = 0;
      for (int p = 0; p < OS; p++) acc_m[p] = 0;
      exp_locked   = 1'b0;
      prev_valid_m = 1'b0;
      cd           = 0;
    end
    tests_run++;
    if (o_bit_valid !== exp_valid) begin
      tests_failed++;
      $display("FAIL strobe cyc=%0d got=%b exp=%b", cyc, o_bit_valid, exp_valid);
    end
    if (exp_valid && exp_q.size() > 0) begin
      got = exp_q.pop_front();
      if (o_bit_valid === 1'b1) begin
        tests_run++;
        if (o_bit !== got[0]) begin
          tests_failed++;
          $display("FAIL bit cyc=%0d got=%b exp=%b", cyc, o_bit, got[0]);
        end
      end
    end
    tests_run++;
    if (o_phase !== exp_phase) begin
      tests_failed++;
      $display("FAIL phase cyc=%0d got=%0d exp=%0d", cyc, o_phase, exp_phase);
    end
    tests_run++;
    if (o_locked !== exp_locked) begin
      tests_failed++;
      $display("FAIL locked cyc=%0d got=%b exp=%b", cyc, o_locked, exp_locked);
    end
    cyc++;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_pl(input string name, input logic [NB_PHASE-1:0] ph, input logic lk);
    tests_run++;
    if (o_phase !== ph || o_locked !== lk) begin
      tests_failed++;
      $display("FAIL %s got phase=%0d locked=%b exp phase=%0d locked=%b",
               name, o_phase, o_locked, ph, lk);
    end
  endtask

  task automatic set_prbs(input int m0, input int m1, input int m2, input int m3);
    mode_fixed = 1'b0;
    mag_m = '{m0, m1, m2, m3};
  endtask

  task automatic test_reset();
    i_enable = 1'b1;
    set_prbs(10, 10, 100, 10);
    do_reset();
  endtask

  task automatic test_acquire_track();
    do_reset();
    run_cycles(261);
    check_pl("acq_first_eval", 2'd2, 1'b0);
    run_cycles(256);
    check_pl("acq_second_eval", 2'd2, 1'b1);
    run_cycles(WIN * 3 - 517);
  endtask

  task automatic test_peak_shift();
    set_prbs(10, 10, 10, 100);
    run_cycles(262);
    if (FREEZE) check_pl("shift_frozen_1", 2'd2, 1'b1);
    else        check_pl("shift_move", 2'd3, 1'b0);
    run_cycles(256);
    if (FREEZE) check_pl("shift_frozen_2", 2'd2, 1'b1);
    else        check_pl("shift_relock", 2'd3, 1'b1);
  endtask

  task automatic test_enable_drop();
    bit found;
    int low_strobes;
    logic [NB_PHASE-1:0] held;
    found = 1'b0;
    low_strobes = 0;
    for (int i = 0; i < WIN + 4; i++) begin
      if (w_m == 30 * OS) begin
        found = 1'b1;
        break;
      end
      step();
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL drop_align got=0 exp=1");
    end
    held = FREEZE ? 2'd2 : 2'd3;
    i_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (o_bit_valid === 1'b1) low_strobes++;
    end
    tests_run++;
    if (low_strobes != 0) begin
      tests_failed++;
      $display("FAIL drop_strobes got=%0d exp=0", low_strobes);
    end
    check_pl("drop_hold", held, 1'b0);
    i_enable = 1'b1;
    run_cycles(261);
    check_pl("reacq_first", 2'd3, 1'b0);
    run_cycles(256);
    check_pl("reacq_second", 2'd3, 1'b1);
  endtask

  task automatic test_tie();
    set_prbs(50, 50, 50, 50);
    do_reset();
    run_cycles(261);
    check_pl("tie_first", 2'd0, 1'b0);
    run_cycles(256);
    check_pl("tie_second", 2'd0, 1'b1);
  endtask

  task automatic test_full_scale();
    mode_fixed = 1'b1;
    fix_m = '{0, -128, 0, 0};
    do_reset();
    run_cycles(256);
    tests_run++;
    if (dut.shadow_q[1] !== 14'd8192 || dut.shadow_q[0] !== 14'd0) begin
      tests_failed++;
      $display("FAIL full_scale_shadow got s1=%0d s0=%0d exp s1=8192 s0=0",
               dut.shadow_q[1], dut.shadow_q[0]);
    end
    run_cycles(5);
    check_pl("full_scale_phase", 2'd1, 1'b0);
    run_cycles(40);
    tests_run++;
    if (o_bit !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_scale_bit got=%b exp=1", o_bit);
    end
  endtask

  task automatic test_reset_midrun();
    set_prbs(10, 10, 100, 10);
    do_reset();
    run_cycles(258);
    tests_run++;
    if (dut.state_q !== 2'd2) begin
      tests_failed++;
      $display("FAIL eval_state got=%0d exp=2", dut.state_q);
    end
    do_reset();
    run_cycles(261);
    check_pl("restart_first", 2'd2, 1'b0);
    run_cycles(256);
    check_pl("restart_second", 2'd2, 1'b1);
    run_cycles(83);
    do_reset();
  endtask

  // Test sequence and final report.
  initial begin
    test_reset();
    test_acquire_track();
    test_peak_shift();
    test_enable_drop();
    test_tie();
    test_full_scale();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
